// File: rtl/onehot_decoder_pkg.sv
// Shared types and helpers for the sequential one-hot decoder.
// States, output-mode encodings and the counter-width helper.
package onehot_decoder_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    GAP    = 2'd2
  } dec_state_t;

  localparam int MODE_LEVEL = 0;
  localparam int MODE_PULSE = 1;

  // Width needed to hold the larger of the two count lengths.
  function automatic int clog2_max(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/onehot_decoder_seq_bin2onehot.sv
// Combinational binary-to-one-hot decode; indices at or above NUM_OUT yield all-zero.
module bin2onehot #(
  parameter int SEL_W   = 3,
  parameter int NUM_OUT = 8
) (
  input  logic [SEL_W-1:0]   sel,
  output logic [NUM_OUT-1:0] onehot
);

  // One comparator per output bit, so an out-of-range index matches none.
  always_comb begin
    onehot = {NUM_OUT{1'b0}};
    for (int i = 0; i < NUM_OUT; i++) begin
      if (sel == i[SEL_W-1:0]) begin
        onehot[i] = 1'b1;
      end else begin
        onehot[i] = 1'b0;
      end
    end
  end

endmodule

// File: rtl/onehot_decoder_seq.sv
// Registered one-hot select driver with valid/ready input, level or timed-pulse output and off-gap.
// Define ONEHOT_DECODER_RANGE_CHECK_EN to add the sticky out-of-range flag port `err`.
module onehot_decoder_seq
  import onehot_decoder_pkg::*;
#(
  parameter int SEL_W      = 3,
  parameter int NUM_OUT    = 8,
  parameter int PULSE_MODE = 1,
  parameter int PULSE_LEN  = 4,
  parameter int GAP_LEN    = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [SEL_W-1:0]   in_sel,
  output logic [NUM_OUT-1:0] out_onehot,
  output logic               out_active,
  output logic [SEL_W-1:0]   out_index
`ifdef ONEHOT_DECODER_RANGE_CHECK_EN
  ,
  output logic               err
`endif
);

  localparam int CNT_W = clog2_max(PULSE_LEN, GAP_LEN);
  localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(PULSE_LEN - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD   = (GAP_LEN > 0) ? CNT_W'(GAP_LEN - 1) : {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  dec_state_t         state_r;
  logic [CNT_W-1:0]   cnt_r;
  logic [NUM_OUT-1:0] onehot_r;
  logic               active_r;
  logic [SEL_W-1:0]   index_r;
  logic [NUM_OUT-1:0] decoded_s;
  logic               accept_s;

  bin2onehot #(
    .SEL_W  (SEL_W),
    .NUM_OUT(NUM_OUT)
  ) u_dec (
    .sel   (in_sel),
    .onehot(decoded_s)
  );

  // Level mode accepts every cycle; pulse mode only once the gap has elapsed.
  assign in_ready = !clr && ((PULSE_MODE == MODE_LEVEL) || (state_r == IDLE));
  assign accept_s = in_valid && in_ready;

  // Main FSM; clr aborts to IDLE but keeps the last index.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r  <= IDLE;
      cnt_r    <= {CNT_W{1'b0}};
      onehot_r <= {NUM_OUT{1'b0}};
      active_r <= 1'b0;
      index_r  <= {SEL_W{1'b0}};
    end else if (clr) begin
      state_r  <= IDLE;
      cnt_r    <= {CNT_W{1'b0}};
      onehot_r <= {NUM_OUT{1'b0}};
      active_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            state_r  <= ACTIVE;
            cnt_r    <= PULSE_LOAD;
            onehot_r <= decoded_s;
            active_r <= 1'b1;
            index_r  <= in_sel;
          end
        end
        ACTIVE: begin
          if (PULSE_MODE == MODE_LEVEL) begin
            if (accept_s) begin
              onehot_r <= decoded_s;
              index_r  <= in_sel;
            end
          end else if (cnt_r == {CNT_W{1'b0}}) begin
            onehot_r <= {NUM_OUT{1'b0}};
            active_r <= 1'b0;
            if (GAP_LEN > 0) begin
              state_r <= GAP;
              cnt_r   <= GAP_LOAD;
            end else begin
              state_r <= IDLE;
            end
          end else begin
            cnt_r <= cnt_r - CNT_ONE;
          end
        end
        GAP: begin
          if (cnt_r == {CNT_W{1'b0}}) begin
            state_r <= IDLE;
          end else begin
            cnt_r <= cnt_r - CNT_ONE;
          end
        end
        default: begin
          state_r  <= IDLE;
          cnt_r    <= {CNT_W{1'b0}};
          onehot_r <= {NUM_OUT{1'b0}};
          active_r <= 1'b0;
        end
      endcase
    end
  end

  assign out_onehot = onehot_r;
  assign out_active = active_r;
  assign out_index  = index_r;

`ifdef ONEHOT_DECODER_RANGE_CHECK_EN
  localparam logic [SEL_W:0] NUM_OUT_W = (SEL_W + 1)'(NUM_OUT);

  logic sel_oor_s;
  logic err_r;

  // Never true when NUM_OUT covers the whole index range, so err stays 0 then.
  assign sel_oor_s = ({1'b0, in_sel} >= NUM_OUT_W);

  // Sticky range error; only rst clears it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_r <= 1'b0;
    end else if (accept_s && sel_oor_s) begin
      err_r <= 1'b1;
    end else begin
      err_r <= err_r;
    end
  end

  assign err = err_r;
`endif

endmodule

// File: tb/tb_onehot_decoder_seq.sv
// Self-checking bench for onehot_decoder_seq: table-driven vectors with an expected-output queue.
// Covers pulse, level, short-pulse/no-gap and out-of-range (NUM_OUT=6) configurations.
module tb_onehot_decoder_seq;

  typedef struct {
    logic [2:0] sel;
    logic [7:0] exp;
  } vec_t;

  typedef struct {
    logic [7:0] onehot;
    logic       ready;
    logic       active;
    logic [2:0] index;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  exp_t sb[$];

  // Default pulse DUT
  logic       p_clr = 1'b0, p_valid = 1'b0, p_ready, p_active;
  logic [2:0] p_sel = 3'd0, p_index;
  logic [7:0] p_onehot;
  // Level-mode DUT
  logic       l_clr = 1'b0, l_valid = 1'b0, l_ready, l_active;
  logic [2:0] l_sel = 3'd0, l_index;
  logic [7:0] l_onehot;
  // PULSE_LEN=1, GAP_LEN=0 DUT
  logic       s_clr = 1'b0, s_valid = 1'b0, s_ready, s_active;
  logic [2:0] s_sel = 3'd0, s_index;
  logic [7:0] s_onehot;
  // NUM_OUT=6 DUT
  logic       x_clr = 1'b0, x_valid = 1'b0, x_ready, x_active;
  logic [2:0] x_sel = 3'd0, x_index;
  logic [5:0] x_onehot;
`ifdef ONEHOT_DECODER_RANGE_CHECK_EN
  logic p_err, l_err, s_err, x_err;
`endif

  onehot_decoder_seq u_pulse (
    .clk(clk), .rst(rst), .clr(p_clr), .in_valid(p_valid), .in_ready(p_ready), .in_sel(p_sel),
    .out_onehot(p_onehot), .out_active(p_active), .out_index(p_index)
`ifdef ONEHOT_DECODER_RANGE_CHECK_EN
    , .err(p_err)
`endif
  );

  onehot_decoder_seq #(.PULSE_MODE(0)) u_level (
    .clk(clk), .rst(rst), .clr(l_clr), .in_valid(l_valid), .in_ready(l_ready), .in_sel(l_sel),
    .out_onehot(l_onehot), .out_active(l_active), .out_index(l_index)
`ifdef ONEHOT_DECODER_RANGE_CHECK_EN
    , .err(l_err)
`endif
  );

  onehot_decoder_seq #(.PULSE_LEN(1), .GAP_LEN(0)) u_short (
    .clk(clk), .rst(rst), .clr(s_clr), .in_valid(s_valid), .in_ready(s_ready), .in_sel(s_sel),
    .out_onehot(s_onehot), .out_active(s_active), .out_index(s_index)
`ifdef ONEHOT_DECODER_RANGE_CHECK_EN
    , .err(s_err)
`endif
  );

  onehot_decoder_seq #(.NUM_OUT(6)) u_six (
    .clk(clk), .rst(rst), .clr(x_clr), .in_valid(x_valid), .in_ready(x_ready), .in_sel(x_sel),
    .out_onehot(x_onehot), .out_active(x_active), .out_index(x_index)
`ifdef ONEHOT_DECODER_RANGE_CHECK_EN
    , .err(x_err)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic sb_check(input string tag, input logic [7:0] oh, input logic rdy,
                          input logic act, input logic [2:0] idx);
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: scoreboard empty, got onehot %0h", tag, oh);
    end else begin
      e = sb.pop_front();
      chk({tag, " onehot"}, 32'(oh), 32'(e.onehot));
      chk({tag, " ready"}, 32'(rdy), 32'(e.ready));
      chk({tag, " active"}, 32'(act), 32'(e.active));
      chk({tag, " index"}, 32'(idx), 32'(e.index));
    end
  endtask

  initial begin
    vec_t ptab[4];
    vec_t ltab[4];
    exp_t e;

    ptab[0] = '{3'd3, 8'h08};
    ptab[1] = '{3'd6, 8'h40};
    ptab[2] = '{3'd0, 8'h01};
    ptab[3] = '{3'd7, 8'h80};
    ltab[0] = '{3'd1, 8'h02};
    ltab[1] = '{3'd2, 8'h04};
    ltab[2] = '{3'd7, 8'h80};
    ltab[3] = '{3'd0, 8'h01};

    // Reset state
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset onehot", 32'(p_onehot), 32'h0);
    chk("reset ready", 32'(p_ready), 32'h1);
    chk("reset active", 32'(p_active), 32'h0);
    chk("reset index", 32'(p_index), 32'h0);

    // Asynchronous reset in the middle of a pulse
    p_valid = 1'b1;
    p_sel   = 3'd5;
    @(posedge clk);
    #1 p_valid = 1'b0;
    @(negedge clk);
    chk("pre-rst onehot", 32'(p_onehot), 32'h20);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("rst mid onehot", 32'(p_onehot), 32'h0);
    chk("rst mid ready", 32'(p_ready), 32'h1);
    chk("rst mid index", 32'(p_index), 32'h0);
    chk("rst mid active", 32'(p_active), 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Pulse mode table: valid held, next select accepted exactly 7 edges later
    @(negedge clk);
    p_valid = 1'b1;
    p_sel   = ptab[0].sel;
    #1 chk("pulse ready idle", 32'(p_ready), 32'h1);
    @(posedge clk);
    for (int i = 0; i < 4; i++) begin
      for (int c = 1; c <= 7; c++) begin
        e.onehot = (c <= 4) ? ptab[i].exp : 8'h00;
        e.active = (c <= 4);
        e.ready  = (c == 7);
        e.index  = ptab[i].sel;
        sb.push_back(e);
      end
      #1;
      if (i < 3) p_sel = ptab[i + 1].sel;
      else p_valid = 1'b0;
      for (int c = 1; c <= 7; c++) begin
        @(negedge clk);
        sb_check($sformatf("pulse v%0d c%0d", i, c), p_onehot, p_ready, p_active, p_index);
        @(posedge clk);
      end
    end

    // Level mode: back-to-back accepts
    @(negedge clk);
    l_valid = 1'b1;
    l_sel   = ltab[0].sel;
    sb.push_back('{ltab[0].exp, 1'b1, 1'b1, ltab[0].sel});
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      if (i < 3) begin
        l_sel = ltab[i + 1].sel;
        sb.push_back('{ltab[i + 1].exp, 1'b1, 1'b1, ltab[i + 1].sel});
      end else begin
        l_valid = 1'b0;
      end
      @(negedge clk);
      sb_check($sformatf("level v%0d", i), l_onehot, l_ready, l_active, l_index);
    end
    @(negedge clk);
    chk("level hold", 32'(l_onehot), 32'h01);

    // PULSE_LEN=1, GAP_LEN=0: one accept every 2 cycles
    s_valid = 1'b1;
    s_sel   = 3'd2;
    @(posedge clk);
    for (int c = 1; c <= 6; c++) begin
      e.onehot = (c % 2 == 1) ? 8'h04 : 8'h00;
      e.active = (c % 2 == 1);
      e.ready  = (c % 2 == 0);
      e.index  = 3'd2;
      sb.push_back(e);
    end
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      sb_check($sformatf("short c%0d", c), s_onehot, s_ready, s_active, s_index);
      @(posedge clk);
    end
    #1 s_valid = 1'b0;

    // clr in cycle 2 of a pulse with a competing valid select
    @(negedge clk);
    p_valid = 1'b1;
    p_sel   = 3'd4;
    @(posedge clk);
    #1 p_valid = 1'b0;
    @(posedge clk);
    #1;
    p_clr   = 1'b1;
    p_valid = 1'b1;
    p_sel   = 3'd1;
    @(negedge clk);
    chk("clr ready low", 32'(p_ready), 32'h0);
    chk("clr pre onehot", 32'(p_onehot), 32'h10);
    @(posedge clk);
    #1;
    p_clr   = 1'b0;
    p_valid = 1'b0;
    @(negedge clk);
    chk("clr onehot", 32'(p_onehot), 32'h0);
    chk("clr active", 32'(p_active), 32'h0);
    chk("clr index kept", 32'(p_index), 32'h4);
    chk("clr ready back", 32'(p_ready), 32'h1);
    @(negedge clk);
    chk("clr not accepted", 32'(p_onehot), 32'h0);

    // Out-of-range select on NUM_OUT=6
    x_valid = 1'b1;
    x_sel   = 3'd7;
    @(posedge clk);
    #1 x_valid = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      chk($sformatf("oor onehot c%0d", c), 32'(x_onehot), 32'h0);
      chk($sformatf("oor active c%0d", c), 32'(x_active), 32'h1);
`ifdef ONEHOT_DECODER_RANGE_CHECK_EN
      chk($sformatf("oor err c%0d", c), 32'(x_err), 32'h1);
`endif
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("oor ready", 32'(x_ready), 32'h1);
    chk("oor index", 32'(x_index), 32'h7);
    x_clr = 1'b1;
    @(posedge clk);
    #1 x_clr = 1'b0;
    @(negedge clk);
`ifdef ONEHOT_DECODER_RANGE_CHECK_EN
    chk("err after clr", 32'(x_err), 32'h1);
`endif
    x_valid = 1'b1;
    x_sel   = 3'd2;
    @(posedge clk);
    #1 x_valid = 1'b0;
    @(negedge clk);
    chk("six sel2 onehot", 32'(x_onehot), 32'h04);
    chk("six sel2 index", 32'(x_index), 32'h2);
`ifdef ONEHOT_DECODER_RANGE_CHECK_EN
    chk("err after valid", 32'(x_err), 32'h1);
    chk("full-range err", 32'(p_err), 32'h0);
`endif
    #1 rst = 1'b1;
    #1;
    chk("six rst onehot", 32'(x_onehot), 32'h0);
`ifdef ONEHOT_DECODER_RANGE_CHECK_EN
    chk("err after rst", 32'(x_err), 32'h0);
`endif
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
